mips_compiler: RTL and testbench

Combinational instruction classifier for the five-stage MIPS pipeline (P7 subset with CP0). Takes a 32-bit instruction word and emits a 6-bit instruction ID consumed by each stage's control and hazard logic, e.g. EX/MEM load/store exception checks. A one-cycle registered copy of the ID is also provided for stage-aligned use.

---
 rtl/mips_compiler_pkg.sv | 87 ++++++++
 rtl/mips_compiler_if.sv | 12 +
 rtl/mips_compiler.sv | 108 ++++++++++
 tb/tb_mips_compiler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_compiler_pkg.sv
// Shared decode constants: instruction IDs, opcode/funct fields, exception codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [5:0] mips_NOP     = 6'd0;
    localparam logic [5:0] mips_ADD     = 6'd1;
    localparam logic [5:0] mips_ADDU    = 6'd2;
    localparam logic [5:0] mips_SUB     = 6'd3;
    localparam logic [5:0] mips_SUBU    = 6'd4;
    localparam logic [5:0] mips_AND     = 6'd5;
    localparam logic [5:0] mips_OR      = 6'd6;
    localparam logic [5:0] mips_XOR     = 6'd7;
    localparam logic [5:0] mips_NOR     = 6'd8;
    localparam logic [5:0] mips_SLT     = 6'd9;
    localparam logic [5:0] mips_SLTU    = 6'd10;
    localparam logic [5:0] mips_SLL     = 6'd11;
    localparam logic [5:0] mips_SRL     = 6'd12;
    localparam logic [5:0] mips_SRA     = 6'd13;
    localparam logic [5:0] mips_SLLV    = 6'd14;
    localparam logic [5:0] mips_SRLV    = 6'd15;
    localparam logic [5:0] mips_SRAV    = 6'd16;
    localparam logic [5:0] mips_ADDI    = 6'd17;
    localparam logic [5:0] mips_ADDIU   = 6'd18;
    localparam logic [5:0] mips_ANDI    = 6'd19;
    localparam logic [5:0] mips_ORI     = 6'd20;
    localparam logic [5:0] mips_XORI    = 6'd21;
    localparam logic [5:0] mips_LUI     = 6'd22;
    localparam logic [5:0] mips_SLTI    = 6'd23;
    localparam logic [5:0] mips_SLTIU   = 6'd24;
    localparam logic [5:0] mips_LW      = 6'd25;
    localparam logic [5:0] mips_LB      = 6'd26;
    localparam logic [5:0] mips_LBU     = 6'd27;
    localparam logic [5:0] mips_LH      = 6'd28;
    localparam logic [5:0] mips_LHU     = 6'd29;
    localparam logic [5:0] mips_SW      = 6'd30;
    localparam logic [5:0] mips_SB      = 6'd31;
    localparam logic [5:0] mips_SH      = 6'd32;
    localparam logic [5:0] mips_BEQ     = 6'd33;
    localparam logic [5:0] mips_BNE     = 6'd34;
    localparam logic [5:0] mips_BLEZ    = 6'd35;
    localparam logic [5:0] mips_BGTZ    = 6'd36;
    localparam logic [5:0] mips_BLTZ    = 6'd37;
    localparam logic [5:0] mips_BGEZ    = 6'd38;
    localparam logic [5:0] mips_J       = 6'd39;
    localparam logic [5:0] mips_JAL     = 6'd40;
    localparam logic [5:0] mips_JR      = 6'd41;
    localparam logic [5:0] mips_JALR    = 6'd42;
    localparam logic [5:0] mips_MULT    = 6'd43;
    localparam logic [5:0] mips_MULTU   = 6'd44;
    localparam logic [5:0] mips_DIV     = 6'd45;
    localparam logic [5:0] mips_DIVU    = 6'd46;
    localparam logic [5:0] mips_MFHI    = 6'd47;
    localparam logic [5:0] mips_MFLO    = 6'd48;
    localparam logic [5:0] mips_MTHI    = 6'd49;
    localparam logic [5:0] mips_MTLO    = 6'd50;
    localparam logic [5:0] mips_MFC0    = 6'd51;
    localparam logic [5:0] mips_MTC0    = 6'd52;
    localparam logic [5:0] mips_ERET    = 6'd53;
    localparam logic [5:0] mips_UNKNOWN = 6'd63;

    localparam logic [5:0] OP_SPECIAL = 6'd0,  OP_REGIMM = 6'd1,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4,  OP_BNE    = 6'd5,  OP_BLEZ = 6'd6,  OP_BGTZ = 6'd7;
    localparam logic [5:0] OP_ADDI    = 6'd8,  OP_ADDIU  = 6'd9,  OP_SLTI = 6'd10, OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12, OP_ORI    = 6'd13, OP_XORI = 6'd14, OP_LUI  = 6'd15;
    localparam logic [5:0] OP_COP0    = 6'd16;
    localparam logic [5:0] OP_LB      = 6'd32, OP_LH     = 6'd33, OP_LW   = 6'd35, OP_LBU  = 6'd36;
    localparam logic [5:0] OP_LHU     = 6'd37, OP_SB     = 6'd40, OP_SH   = 6'd41, OP_SW   = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0,  FN_SRL   = 6'd2,  FN_SRA  = 6'd3,  FN_SLLV = 6'd4;
    localparam logic [5:0] FN_SRLV = 6'd6,  FN_SRAV  = 6'd7,  FN_JR   = 6'd8,  FN_JALR = 6'd9;
    localparam logic [5:0] FN_MFHI = 6'd16, FN_MTHI  = 6'd17, FN_MFLO = 6'd18, FN_MTLO = 6'd19;
    localparam logic [5:0] FN_MULT = 6'd24, FN_MULTU = 6'd25, FN_DIV  = 6'd26, FN_DIVU = 6'd27;
    localparam logic [5:0] FN_ADD  = 6'd32, FN_ADDU  = 6'd33, FN_SUB  = 6'd34, FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36, FN_OR    = 6'd37, FN_XOR  = 6'd38, FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42, FN_SLTU  = 6'd43;

    localparam logic [4:0] RS_MF   = 5'd0, RS_MT = 5'd4;
    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    // Exception codes reported by the stage registers.
    localparam logic [4:0] Int  = 5'd0;
    localparam logic [4:0] AdEL = 5'd4;
    localparam logic [4:0] AdES = 5'd5;

endpackage

// File: rtl/mips_compiler_if.sv
// Instruction word in, decoded ID (combinational + registered) and reserved-instruction flag out.
// Latency: n/a (bundle of wires).
// Backpressure: none.
interface mips_compiler_if;
    logic [31:0] Instr;
    logic [5:0]  MIPS;
    logic [5:0]  MIPS_R;
    logic        RI;

    modport master (output Instr, input MIPS, input MIPS_R, input RI);
    modport slave  (input Instr, output MIPS, output MIPS_R, output RI);
endinterface

// File: rtl/mips_compiler.sv
// Classifies a MIPS instruction word into a 6-bit ID shared by every pipeline stage.
// Latency: MIPS/RI combinational; MIPS_R one clk later.
// Backpressure: none; a new word may be presented every cycle.
module mips_compiler
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mips_compiler_if.slave   bus
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] id;

    assign op    = bus.Instr[31:26];
    assign rs    = bus.Instr[25:21];
    assign rt    = bus.Instr[20:16];
    assign funct = bus.Instr[5:0];

    // The all-zero word is sll $0,$0,0 but is reported as NOP first.
    always_comb begin
        id = mips_UNKNOWN;
        if (bus.Instr == 32'h0000_0000) begin
            id = mips_NOP;
        end else begin
            case (op)
                OP_SPECIAL: begin
                    case (funct)
                        FN_SLL:   id = mips_SLL;
                        FN_SRL:   id = mips_SRL;
                        FN_SRA:   id = mips_SRA;
                        FN_SLLV:  id = mips_SLLV;
                        FN_SRLV:  id = mips_SRLV;
                        FN_SRAV:  id = mips_SRAV;
                        FN_JR:    id = mips_JR;
                        FN_JALR:  id = mips_JALR;
                        FN_MFHI:  id = mips_MFHI;
                        FN_MTHI:  id = mips_MTHI;
                        FN_MFLO:  id = mips_MFLO;
                        FN_MTLO:  id = mips_MTLO;
                        FN_MULT:  id = mips_MULT;
                        FN_MULTU: id = mips_MULTU;
                        FN_DIV:   id = mips_DIV;
                        FN_DIVU:  id = mips_DIVU;
                        FN_ADD:   id = mips_ADD;
                        FN_ADDU:  id = mips_ADDU;
                        FN_SUB:   id = mips_SUB;
                        FN_SUBU:  id = mips_SUBU;
                        FN_AND:   id = mips_AND;
                        FN_OR:    id = mips_OR;
                        FN_XOR:   id = mips_XOR;
                        FN_NOR:   id = mips_NOR;
                        FN_SLT:   id = mips_SLT;
                        FN_SLTU:  id = mips_SLTU;
                        default:  id = mips_UNKNOWN;
                    endcase
                end
                OP_REGIMM: begin
                    if (rt == RT_BLTZ)      id = mips_BLTZ;
                    else if (rt == RT_BGEZ) id = mips_BGEZ;
                    else                    id = mips_UNKNOWN;
                end
                OP_COP0: begin
                    // ERET is an exact-word match; MFC0/MTC0 look only at rs.
                    if (bus.Instr == ERET_WORD) id = mips_ERET;
                    else if (rs == RS_MF)       id = mips_MFC0;
                    else if (rs == RS_MT)       id = mips_MTC0;
                    else                        id = mips_UNKNOWN;
                end
                OP_J:     id = mips_J;
                OP_JAL:   id = mips_JAL;
                OP_BEQ:   id = mips_BEQ;
                OP_BNE:   id = mips_BNE;
                OP_BLEZ:  id = mips_BLEZ;
                OP_BGTZ:  id = mips_BGTZ;
                OP_ADDI:  id = mips_ADDI;
                OP_ADDIU: id = mips_ADDIU;
                OP_SLTI:  id = mips_SLTI;
                OP_SLTIU: id = mips_SLTIU;
                OP_ANDI:  id = mips_ANDI;
                OP_ORI:   id = mips_ORI;
                OP_XORI:  id = mips_XORI;
                OP_LUI:   id = mips_LUI;
                OP_LB:    id = mips_LB;
                OP_LH:    id = mips_LH;
                OP_LW:    id = mips_LW;
                OP_LBU:   id = mips_LBU;
                OP_LHU:   id = mips_LHU;
                OP_SB:    id = mips_SB;
                OP_SH:    id = mips_SH;
                OP_SW:    id = mips_SW;
                default:  id = mips_UNKNOWN;
            endcase
        end
    end

    assign bus.MIPS = id;
    assign bus.RI   = (id == mips_UNKNOWN);

    always_ff @(posedge clk) begin
        if (reset) bus.MIPS_R <= mips_NOP;
        else       bus.MIPS_R <= id;
    end

endmodule

// File: tb/tb_mips_compiler.sv
// Bench for mips_compiler: table-driven reference model, per-cycle compare, directed literals.
module tb_mips_compiler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   r_tab [64];
    int   o_tab [64];
    int   exp_r = 0;
    bit   r_known = 1'b0;
    bit   chk_en = 1'b0;

    mips_compiler_if bus ();

    mips_compiler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (Instr=%08h t=%0t)", name, act, req, bus.Instr, $time);
        end
    endtask

    // ID order as listed by the architecture table, keyed by funct / opcode.
    task automatic build_tables();
        for (int i = 0; i < 64; i++) begin
            r_tab[i] = 63;
            o_tab[i] = 63;
        end
        r_tab[0] = 11;  r_tab[2] = 12;  r_tab[3] = 13;  r_tab[4] = 14;
        r_tab[6] = 15;  r_tab[7] = 16;  r_tab[8] = 41;  r_tab[9] = 42;
        r_tab[16] = 47; r_tab[17] = 49; r_tab[18] = 48; r_tab[19] = 50;
        r_tab[24] = 43; r_tab[25] = 44; r_tab[26] = 45; r_tab[27] = 46;
        for (int i = 0; i < 8; i++) r_tab[32 + i] = 1 + i;
        r_tab[42] = 9;  r_tab[43] = 10;
        o_tab[2] = 39;  o_tab[3] = 40;  o_tab[4] = 33;  o_tab[5] = 34;
        o_tab[6] = 35;  o_tab[7] = 36;  o_tab[8] = 17;  o_tab[9] = 18;
        o_tab[10] = 23; o_tab[11] = 24; o_tab[12] = 19; o_tab[13] = 20;
        o_tab[14] = 21; o_tab[15] = 22;
        o_tab[32] = 26; o_tab[33] = 28; o_tab[35] = 25; o_tab[36] = 27;
        o_tab[37] = 29; o_tab[40] = 31; o_tab[41] = 32; o_tab[43] = 30;
    endtask

    function automatic int model(input logic [31:0] w);
        int op, rs, rt;
        op = int'(w[31:26]);
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        if (w == 32'h0) return 0;
        if (op == 0) return r_tab[w[5:0]];
        if (op == 1) return (rt == 0) ? 37 : (rt == 1) ? 38 : 63;
        if (op == 16) begin
            if (w == 32'h4200_0018) return 53;
            return (rs == 0) ? 51 : (rs == 4) ? 52 : 63;
        end
        return o_tab[op];
    endfunction

    // Expected registered ID: captured from the model at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_r <= 0;
            r_known <= 1'b1;
        end else begin
            exp_r <= model(bus.Instr);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_mips", int'(bus.MIPS), model(bus.Instr));
            chk("cyc_ri", int'(bus.RI), int'(model(bus.Instr) == 63));
            if (r_known) chk("cyc_mips_r", int'(bus.MIPS_R), exp_r);
        end
    end

    task automatic apply(input logic [31:0] w);
        @(posedge clk);
        #1;
        bus.Instr = w;
    endtask

    task automatic lit(input string name, input logic [31:0] w, input int req);
        apply(w);
        #1;
        chk(name, int'(bus.MIPS), req);
        chk({name, "_model"}, model(w), req);
        chk({name, "_ri"}, int'(bus.RI), int'(req == 63));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        build_tables();
        reset = 1'b1;
        bus.Instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mips_r", int'(bus.MIPS_R), 0);
        chk_en = 1'b1;
        reset = 1'b0;

        lit("nop",     32'h0000_0000, 0);
        lit("addu",    32'h0085_1021, 2);
        lit("lw",      32'h8FA8_0004, 25);
        lit("sw",      32'hAFA8_0004, 30);
        lit("lh",      32'h8508_0002, 28);
        lit("bgez",    32'h0421_0003, 38);
        lit("bltz",    32'h0400_0003, 37);
        lit("regimm_rs2_rt1", 32'h0441_0003, 38);
        lit("regimm_rt2",     32'h0402_0003, 63);
        lit("mfc0",    32'h4008_6000, 51);
        lit("mtc0",    32'h4088_6000, 52);
        lit("eret",    32'h4200_0018, 53);
        lit("eret_near", 32'h4200_0019, 63);
        lit("op31",    32'h7C00_0000, 63);
        lit("funct1",  32'h0000_0001, 63);
        lit("sll_nonzero", 32'h0001_0040, 11);

        // Registered output tracking and synchronous reset.
        apply(32'h8FA8_0004);
        @(posedge clk); #1;
        chk("mips_r_lw", int'(bus.MIPS_R), 25);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mips_r_reset", int'(bus.MIPS_R), 0);
        chk("mips_during_reset", int'(bus.MIPS), 25);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mips_r_after_reset", int'(bus.MIPS_R), 25);

        // Every opcode x funct with small random rs/rt so REGIMM/COP0 branches are hit.
        for (int op = 0; op < 64; op++) begin
            for (int fn = 0; fn < 64; fn++) begin
                w = {op[5:0], 5'($urandom_range(0, 5)), 5'($urandom_range(0, 3)),
                     10'($urandom), fn[5:0]};
                apply(w);
            end
        end

        // Fully random words with occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            apply($urandom);
            reset = ($urandom_range(0, 15) == 0);
        end
        apply(32'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
